magnitude_approx_stage: RTL and testbench
=========================================

Name: magnitude_approx_stage

Overview:
- Classifier stage directly upstream of the threshold comparison stage.
- Takes one FFT output frame of N_SAMPLES complex bins (signed real/imag pairs) and computes an approximate magnitude per bin.
- Uses alpha-max-beta-min with alpha=1, beta=1/2, one bin per cycle.
- Presents the full magnitude array, held stable, to the comparison stage through a val/rdy handshake.

Parameters:
- BIT_WIDTH, 32, width of each real/imag input word and each magnitude output word.
- DECIMAL_PT, 16, fixed-point position. Informational only; the magnitude keeps the input Q format, and no shift is applied.
- N_SAMPLES, 8, bins per frame. Must be >= 2.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- recv_real  input  BIT_WIDTH x N_SAMPLES  signed real parts, bin 0..N_SAMPLES-1
- recv_imag  input  BIT_WIDTH x N_SAMPLES  signed imaginary parts
- recv_val  input  1  input frame valid
- recv_rdy  output  1  stage can accept a frame
- send_msg  output  BIT_WIDTH x N_SAMPLES  unsigned magnitudes; feeds the comparison stage mag_in
- send_val  output  1  magnitude frame valid
- send_rdy  input  1  downstream accepts the frame

Behaviour:
- Clocking and reset: clk; reset is synchronous, active-high.
- Reset values:
  - state=IDLE, idx=0.
  - recv_rdy=1, send_val=0.
  - all send_msg words=0.
  - input latches=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - recv_rdy=1, send_val=0.
  - On recv_val && recv_rdy: latch all recv_real/recv_imag into internal registers, idx<=0, go to CALC.
- CALC:
  - recv_rdy=0, send_val=0.
  - Each cycle: send_msg[idx] <= mag(latched_real[idx], latched_imag[idx]); idx <= idx+1.
  - When idx==N_SAMPLES-1 on a clock edge, write the last bin and go to DONE.
  - idx counter width is $clog2(N_SAMPLES)+1 so the terminal test never wraps.
- DONE:
  - send_val=1, recv_rdy=0, send_msg held stable.
  - On send_val && send_rdy, go to IDLE.
  - send_msg retains its values after leaving DONE, until overwritten bin by bin in the next CALC.
- Latency:
  - Frame accepted at edge E0; send_val rises after edge E(N_SAMPLES).
  - Earliest next accept is the cycle after the send handshake. No same-cycle bypass from DONE to accept.
- Throughput: one frame per N_SAMPLES+2 cycles when send_rdy is held high.
- Arithmetic:
  - a=|re|, b=|im|, computed as unsigned BIT_WIDTH values.
  - |-2^(BIT_WIDTH-1)| = 2^(BIT_WIDTH-1), which is representable unsigned; no saturation.
  - mag = max(a,b) + (min(a,b) >> 1), logical shift, truncating.
  - Upper bound is 3*2^(BIT_WIDTH-2), so the result fits BIT_WIDTH with no overflow.
  - Ties (a==b): max=a, min=b.
- Boundary conditions:
  - recv_val while not in IDLE: ignored, because recv_rdy=0.
  - Input changes after accept have no effect, because inputs are latched.
  - send_rdy asserted outside DONE has no effect.
  - Reset mid-CALC or mid-DONE: return to IDLE on the next edge, send_val=0, send_msg cleared to 0. The partial frame is discarded.
  - send_rdy held low in DONE: stall indefinitely with outputs stable.

Decomposition:
- Shared package classifier_pkg holds:
  - the state enum typedef (IDLE, CALC, DONE), 2 bits;
  - the constant for the beta shift (1).
- One combinational sub-module, magnitude_approx_unit:
  - inputs: one real/imag pair; output: one magnitude;
  - handles abs, max/min select and the add.
  - Instantiated once and muxed by idx.

Test Plan:
- Basic values (BIT_WIDTH=32, N_SAMPLES=8): bin0 re=3 im=-4 -> 5; bin1 re=-7 im=-7 -> 10; bin2 re=0 im=0 -> 0; bin3 re=0x00010000 im=0 -> 0x00010000. send_val rises exactly 8 cycles after the accept edge.
- Extremes: re=0x80000000 im=0 -> 0x80000000; re=0x80000000 im=0x80000000 -> 0xC0000000; re=0x7FFFFFFF im=1 -> 0x7FFFFFFF.
- Backpressure: hold send_rdy=0 for 5 cycles in DONE -> send_val stays 1, send_msg unchanged, recv_rdy=0, recv_val pulses ignored. Raise send_rdy -> handshake, recv_rdy=1 the next cycle.
- Input isolation: change recv_real/recv_imag every cycle during CALC -> outputs reflect only the frame latched at the accept edge.
- Reset mid-CALC at idx=4 -> next cycle state IDLE, recv_rdy=1, send_val=0, all send_msg=0. A new frame then completes normally.
- Back-to-back: two frames with recv_val=1 and send_rdy=1 throughout -> second accept occurs 1 cycle after the first send handshake, and both frames are correct.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared definitions for the classifier magnitude stage: FSM encoding and
// the beta term of the alpha-max-beta-min approximation.
package classifier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // beta = 1/2 is realised as a logical right shift of min(|re|,|im|)
    localparam int BETA_SHIFT = 1;

endpackage

// File: rtl/magnitude_approx_stage_if.sv
// Frame-in / magnitude-frame-out bus of the magnitude stage; the stage
// takes the slave view, its feeder and the comparison stage the master view.
interface magnitude_approx_stage_if #(
    parameter int BIT_WIDTH = 32,
    parameter int N_SAMPLES = 8
);
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_real;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_imag;
    logic                                recv_val;
    logic                                recv_rdy;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg;
    logic                                send_val;
    logic                                send_rdy;

    modport master (
        output recv_real, recv_imag, recv_val, send_rdy,
        input  recv_rdy, send_msg, send_val
    );

    modport slave (
        input  recv_real, recv_imag, recv_val, send_rdy,
        output recv_rdy, send_msg, send_val
    );
endinterface

// File: rtl/magnitude_approx_unit.sv
// Combinational alpha-max-beta-min magnitude of one signed complex bin:
// max(|re|,|im|) + (min(|re|,|im|) >> 1), result unsigned and same width.
module magnitude_approx_unit
    import classifier_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic signed [BIT_WIDTH-1:0] re_i,
    input  logic signed [BIT_WIDTH-1:0] im_i,
    output logic        [BIT_WIDTH-1:0] mag_o
);

    // Negating the most negative value wraps back onto 2^(W-1), which is the
    // correct unsigned magnitude, so no saturation is required.
    function automatic logic [BIT_WIDTH-1:0] abs_u(input logic signed [BIT_WIDTH-1:0] x);
        return x[BIT_WIDTH-1] ? BIT_WIDTH'(-x) : BIT_WIDTH'(x);
    endfunction

    logic [BIT_WIDTH-1:0] a;
    logic [BIT_WIDTH-1:0] b;
    logic [BIT_WIDTH-1:0] mx;
    logic [BIT_WIDTH-1:0] mn;

    always_comb begin
        a  = abs_u(re_i);
        b  = abs_u(im_i);
        mx = (a >= b) ? a : b;
        mn = (a >= b) ? b : a;
        mag_o = mx + (mn >> BETA_SHIFT);
    end

endmodule

// File: rtl/magnitude_approx_stage.sv
// Latches one complex FFT frame, computes one approximate magnitude per cycle
// and holds the finished magnitude frame for the threshold comparison stage.
module magnitude_approx_stage
    import classifier_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int DECIMAL_PT = 16,
    parameter int N_SAMPLES  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    magnitude_approx_stage_if.slave   bus
);

    localparam int              IDX_W    = $clog2(N_SAMPLES) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);

    // The Q format passes through untouched; DECIMAL_PT only documents it.
    if (DECIMAL_PT >= BIT_WIDTH) begin : g_qfmt_integer_only
    end

    state_e                              state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] re_q;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] im_q;
    logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] msg_q;
    logic [IDX_W-2:0]                    sel;
    logic [BIT_WIDTH-1:0]                mag;
    logic                                accept;

    assign sel    = idx_q[IDX_W-2:0];
    assign accept = (state_q == IDLE) && bus.recv_val;

    magnitude_approx_unit #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_unit (
        .re_i  ($signed(re_q[sel])),
        .im_i  ($signed(im_q[sel])),
        .mag_o (mag)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.recv_val) begin
                    state_d = CALC;
                    idx_d   = '0;
                end
            end
            CALC: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) state_d = DONE;
            end
            DONE: begin
                if (bus.send_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            re_q    <= '0;
            im_q    <= '0;
            msg_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                re_q <= bus.recv_real;
                im_q <= bus.recv_imag;
            end
            if (state_q == CALC) msg_q[sel] <= mag;
        end
    end

    assign bus.recv_rdy = (state_q == IDLE);
    assign bus.send_val = (state_q == DONE);
    assign bus.send_msg = msg_q;

endmodule

// File: tb/tb_magnitude_approx_stage.sv
// Directed bench for magnitude_approx_stage: reset, arithmetic extremes,
// backpressure, input isolation, mid-frame reset and back-to-back frames.
module tb_magnitude_approx_stage;

    localparam int W = 32;
    localparam int N = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    magnitude_approx_stage_if #(.BIT_WIDTH(W), .N_SAMPLES(N)) bus ();

    magnitude_approx_stage #(
        .BIT_WIDTH  (W),
        .DECIMAL_PT (16),
        .N_SAMPLES  (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [N-1:0][W-1:0] a_re, a_im, a_mag;
    logic [N-1:0][W-1:0] b_re, b_im, b_mag;
    logic [N-1:0][W-1:0] zero_frame;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag, input logic [N-1:0][W-1:0] exp);
        for (int i = 0; i < N; i++)
            check($sformatf("%s[%0d]", tag, i), bus.send_msg[i], exp[i]);
    endtask

    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            bus.recv_real[i] = $urandom;
            bus.recv_imag[i] = $urandom;
        end
    endtask

    initial begin
        int n;
        int done_cnt;
        int acc_cnt;
        int hs_c[3];
        int acc_c[2];
        logic took;

        // Frame A: basic values and arithmetic extremes
        a_re[0] = 32'd3;          a_im[0] = -32'sd4;        a_mag[0] = 32'd5;
        a_re[1] = -32'sd7;        a_im[1] = -32'sd7;        a_mag[1] = 32'd10;
        a_re[2] = 32'd0;          a_im[2] = 32'd0;          a_mag[2] = 32'd0;
        a_re[3] = 32'h0001_0000;  a_im[3] = 32'd0;          a_mag[3] = 32'h0001_0000;
        a_re[4] = 32'h8000_0000;  a_im[4] = 32'd0;          a_mag[4] = 32'h8000_0000;
        a_re[5] = 32'h8000_0000;  a_im[5] = 32'h8000_0000;  a_mag[5] = 32'hC000_0000;
        a_re[6] = 32'h7FFF_FFFF;  a_im[6] = 32'd1;          a_mag[6] = 32'h7FFF_FFFF;
        a_re[7] = 32'd5;          a_im[7] = -32'sd20;       a_mag[7] = 32'd22;
        // Frame B: re=k, im=-2k for k=1..8 -> 2k + (k>>1)
        b_re[0] = 32'd1; b_im[0] = -32'sd2;  b_mag[0] = 32'd2;
        b_re[1] = 32'd2; b_im[1] = -32'sd4;  b_mag[1] = 32'd5;
        b_re[2] = 32'd3; b_im[2] = -32'sd6;  b_mag[2] = 32'd7;
        b_re[3] = 32'd4; b_im[3] = -32'sd8;  b_mag[3] = 32'd10;
        b_re[4] = 32'd5; b_im[4] = -32'sd10; b_mag[4] = 32'd12;
        b_re[5] = 32'd6; b_im[5] = -32'sd12; b_mag[5] = 32'd15;
        b_re[6] = 32'd7; b_im[6] = -32'sd14; b_mag[6] = 32'd17;
        b_re[7] = 32'd8; b_im[7] = -32'sd16; b_mag[7] = 32'd20;
        zero_frame = '0;

        bus.recv_real = '0;
        bus.recv_imag = '0;
        bus.recv_val  = 1'b0;
        bus.send_rdy  = 1'b0;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_recv_rdy", W'(bus.recv_rdy), 1);
        check("rst_send_val", W'(bus.send_val), 0);
        check_frame("rst_msg", zero_frame);

        // Frame A; inputs scrambled and recv_val/send_rdy toggled during CALC
        bus.recv_real = a_re;
        bus.recv_imag = a_im;
        bus.recv_val  = 1'b1;
        tick();
        check("calc_recv_rdy", W'(bus.recv_rdy), 0);
        for (int k = 1; k <= N; k++) begin
            drive_random();
            bus.recv_val = 1'($urandom_range(0, 1));
            bus.send_rdy = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("lat_send_val_E%0d", k), W'(bus.send_val), W'(k == N));
        end
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b0;
        check_frame("frameA", a_mag);

        // Backpressure: stall in DONE with recv_val pulses
        for (int k = 0; k < 5; k++) begin
            bus.recv_real = b_re;
            bus.recv_imag = b_im;
            bus.recv_val  = 1'b1;
            tick();
            check("stall_send_val", W'(bus.send_val), 1);
            check("stall_recv_rdy", W'(bus.recv_rdy), 0);
            check("stall_msg0", bus.send_msg[0], a_mag[0]);
            check("stall_msg5", bus.send_msg[5], a_mag[5]);
        end
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b1;
        tick();
        bus.send_rdy = 1'b0;
        check("hs_recv_rdy", W'(bus.recv_rdy), 1);
        check("hs_send_val", W'(bus.send_val), 0);
        check_frame("retainA", a_mag);

        // Reset while CALC holds idx=4
        bus.recv_real = b_re;
        bus.recv_imag = b_im;
        bus.recv_val  = 1'b1;
        tick();
        bus.recv_val = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_recv_rdy", W'(bus.recv_rdy), 1);
        check("midrst_send_val", W'(bus.send_val), 0);
        check_frame("midrst_msg", zero_frame);

        bus.recv_val = 1'b1;
        tick();
        bus.recv_val = 1'b0;
        n = 0;
        while (!bus.send_val && n < 20) begin
            tick();
            n++;
        end
        check("frameB_latency", W'(n), W'(N));
        check_frame("frameB", b_mag);

        // Back-to-back: recv_val and send_rdy held high
        done_cnt = 0;
        acc_cnt  = 0;
        hs_c     = '{-100, -100, -100};
        acc_c    = '{-100, -100};
        bus.recv_real = a_re;
        bus.recv_imag = a_im;
        bus.recv_val  = 1'b1;
        bus.send_rdy  = 1'b1;
        for (int c = 0; c < 40 && done_cnt < 3; c++) begin
            took = 1'b0;
            if (bus.send_val) begin
                check_frame($sformatf("b2b_done%0d", done_cnt), (done_cnt == 1) ? a_mag : b_mag);
                hs_c[done_cnt] = c;
                done_cnt++;
            end
            if (bus.recv_rdy && bus.recv_val && acc_cnt < 2) begin
                acc_c[acc_cnt] = c;
                acc_cnt++;
                took = 1'b1;
            end
            tick();
            if (took && acc_cnt == 1) begin
                bus.recv_real = b_re;
                bus.recv_imag = b_im;
            end
            if (took && acc_cnt == 2) bus.recv_val = 1'b0;
        end
        bus.send_rdy = 1'b0;
        check("b2b_done_count", W'(done_cnt), 3);
        check("b2b_accept1_gap", W'(acc_c[0] - hs_c[0]), 1);
        check("b2b_accept2_gap", W'(acc_c[1] - hs_c[1]), 1);
        check("b2b_period", W'(hs_c[2] - hs_c[1]), W'(N + 2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
